axil_decode_bus: RTL

Parametrised AXI4-Lite 1-to-N address-decoding bus bridge. One upstream master port (s0) fans out to NUM_SLAVES downstream slave ports (m). Slave regions are set by base/mask parameters. Independent write and read engines each carry one outstanding transaction with full valid/ready handshakes on every channel. Unmapped accesses complete locally with DECERR.

---
 rtl/axil_decode_bus.sv | 331 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_decode_bus.sv
// AXI4-Lite 1-to-N address-decoding bridge.
// One write and one read transaction in flight; misses return DECERR.
module axil_decode_bus #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 2,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {8'h10, 8'h00},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {8'hF0, 8'hF0}
) (
    input  logic                               axi_aclk,
    input  logic                               axi_areset,
    input  logic [ADDR_WIDTH-1:0]              s0_axi_awaddr,
    input  logic                               s0_axi_awvalid,
    output logic                               s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]              s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]            s0_axi_wstrb,
    input  logic                               s0_axi_wvalid,
    output logic                               s0_axi_wready,
    output logic [RESP_WIDTH-1:0]              s0_axi_bresp,
    output logic                               s0_axi_bvalid,
    input  logic                               s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]              s0_axi_araddr,
    input  logic                               s0_axi_arvalid,
    output logic                               s0_axi_arready,
    output logic [DATA_WIDTH-1:0]              s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]              s0_axi_rresp,
    output logic                               s0_axi_rvalid,
    input  logic                               s0_axi_rready,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [NUM_SLAVES-1:0]              m_axi_awvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_awready,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic [NUM_SLAVES-1:0]              m_axi_wvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_wready,
    input  logic [NUM_SLAVES*RESP_WIDTH-1:0]   m_axi_bresp,
    input  logic [NUM_SLAVES-1:0]              m_axi_bvalid,
    output logic [NUM_SLAVES-1:0]              m_axi_bready,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [NUM_SLAVES-1:0]              m_axi_arvalid,
    input  logic [NUM_SLAVES-1:0]              m_axi_arready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [NUM_SLAVES*RESP_WIDTH-1:0]   m_axi_rresp,
    input  logic [NUM_SLAVES-1:0]              m_axi_rvalid,
    output logic [NUM_SLAVES-1:0]              m_axi_rready
);

    localparam int N  = NUM_SLAVES;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH / 8;
    localparam int RW = RESP_WIDTH;
    localparam logic [RW-1:0] DECERR = RW'(3);

    typedef enum logic [1:0] {
        W_IDLE, W_ISSUE, W_RESP, W_RETURN
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE, R_ISSUE, R_WAIT, R_RETURN
    } r_state_t;

    // One-hot slave select; lowest index wins on overlap, all-zero on miss.
    function automatic logic [N-1:0] decode(input logic [AW-1:0] a);
        logic [N-1:0] oh;
        oh = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if ((a & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                oh    = '0;
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

    w_state_t        w_state_q, w_state_d;
    logic            aw_got_q, aw_got_d;
    logic            w_got_q, w_got_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [N-1:0]    w_sel_q, w_sel_d;
    logic [N-1:0]    awvalid_q, awvalid_d;
    logic [N-1:0]    wvalid_q, wvalid_d;
    logic [N-1:0]    bready_q, bready_d;
    logic            bvalid_q, bvalid_d;
    logic [RW-1:0]   bresp_q, bresp_d;

    r_state_t        r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic [AW-1:0]   ar_addr_q, ar_addr_d;
    logic [N-1:0]    r_sel_q, r_sel_d;
    logic [N-1:0]    arvalid_q, arvalid_d;
    logic [N-1:0]    rready_q, rready_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [RW-1:0]   rresp_q, rresp_d;

    logic [RW-1:0]   b_resp_mux;
    logic [DW-1:0]   r_data_mux;
    logic [RW-1:0]   r_resp_mux;

    // Select the response fields of the slave each engine is talking to.
    always_comb begin
        b_resp_mux = '0;
        r_data_mux = '0;
        r_resp_mux = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel_q[k]) begin
                b_resp_mux = m_axi_bresp[k*RW +: RW];
            end
            if (r_sel_q[k]) begin
                r_data_mux = m_axi_rdata[k*DW +: DW];
                r_resp_mux = m_axi_rresp[k*RW +: RW];
            end
        end
    end

    // Write engine state and registered outputs.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            w_sel_q   <= '0;
            awvalid_q <= '0;
            wvalid_q  <= '0;
            bready_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_addr_q <= aw_addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            w_sel_q   <= w_sel_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write engine next state: collect AW and W, issue, wait B, return.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_addr_d = aw_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        w_sel_d   = w_sel_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (s0_axi_awvalid && awready_q) begin
                    aw_addr_d = s0_axi_awaddr;
                    aw_got_d  = 1'b1;
                end
                if (s0_axi_wvalid && wready_q) begin
                    wdata_d = s0_axi_wdata;
                    wstrb_d = s0_axi_wstrb;
                    w_got_d = 1'b1;
                end
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_d && w_got_d) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_sel_d   = decode(aw_addr_d);
                    if (|w_sel_d) begin
                        awvalid_d = w_sel_d;
                        wvalid_d  = w_sel_d;
                        w_state_d = W_ISSUE;
                    end else begin
                        bvalid_d  = 1'b1;
                        bresp_d   = DECERR;
                        w_state_d = W_RETURN;
                    end
                end
            end
            W_ISSUE: begin
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (awvalid_q == '0 && wvalid_q == '0) begin
                    bready_d  = w_sel_q;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (|(bready_q & m_axi_bvalid)) begin
                    bready_d  = '0;
                    bvalid_d  = 1'b1;
                    bresp_d   = b_resp_mux;
                    w_state_d = W_RETURN;
                end
            end
            W_RETURN: begin
                if (s0_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read engine state and registered outputs.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            ar_addr_q <= '0;
            r_sel_q   <= '0;
            arvalid_q <= '0;
            rready_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            ar_addr_q <= ar_addr_d;
            r_sel_q   <= r_sel_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read engine next state: accept AR, issue, wait R, return.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        ar_addr_d = ar_addr_q;
        r_sel_d   = r_sel_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s0_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    ar_addr_d = s0_axi_araddr;
                    r_sel_d   = decode(s0_axi_araddr);
                    if (|r_sel_d) begin
                        arvalid_d = r_sel_d;
                        r_state_d = R_ISSUE;
                    end else begin
                        rvalid_d  = 1'b1;
                        rdata_d   = '0;
                        rresp_d   = DECERR;
                        r_state_d = R_RETURN;
                    end
                end
            end
            R_ISSUE: begin
                if (|(arvalid_q & m_axi_arready)) begin
                    arvalid_d = '0;
                    rready_d  = r_sel_q;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (|(rready_q & m_axi_rvalid)) begin
                    rready_d  = '0;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_data_mux;
                    rresp_d   = r_resp_mux;
                    r_state_d = R_RETURN;
                end
            end
            R_RETURN: begin
                if (s0_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_arready = arready_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = rresp_q;

    assign m_axi_awaddr   = {N{aw_addr_q}};
    assign m_axi_wdata    = {N{wdata_q}};
    assign m_axi_wstrb    = {N{wstrb_q}};
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;
    assign m_axi_araddr   = {N{ar_addr_q}};
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_rready   = rready_q;

endmodule
